// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the decode-stage pipeline controller: opcode values,
// control-field encodings, the ID/EX control bundle and the stall FSM states.
package pipe_ctrl_pkg;

    // Opcode values. Opcode 4 is unassigned and decodes to an all-zero bundle.
    localparam int unsigned OpRtype = 0;
    localparam int unsigned OpJal   = 1;
    localparam int unsigned OpBeq   = 2;
    localparam int unsigned OpAddi  = 3;
    localparam int unsigned OpLw    = 5;
    localparam int unsigned OpSw    = 6;
    localparam int unsigned OpJ     = 7;

    typedef enum logic [1:0] {
        AluAdd   = 2'd0,
        AluSub   = 2'd1,
        AluFunct = 2'd2
    } alu_op_e;

    // Selects the write register: rt, rd, or the all-ones link register.
    typedef enum logic [1:0] {
        DstRt   = 2'd0,
        DstRd   = 2'd1,
        DstLink = 2'd2
    } reg_dst_e;

    // Selects the write-back source: ALU result, load data, or return address.
    typedef enum logic [1:0] {
        M2rAlu  = 2'd0,
        M2rMem  = 2'd1,
        M2rLink = 2'd2
    } mem_to_reg_e;

    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        mem_write;
        logic        mem_read;
        reg_dst_e    reg_dst;
        alu_op_e     alu_op;
        mem_to_reg_e mem_to_reg;
    } ctrl_t;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHold = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational opcode-to-control decode.
// Ports:
//   op   - opcode field of the IF/ID instruction
//   ctrl - control bundle; fields not used by an opcode are zero
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_W'(OpRtype): begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DstRd;
                ctrl.alu_op    = AluFunct;
            end
            OP_W'(OpJal): begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DstLink;
                ctrl.mem_to_reg = M2rLink;
                ctrl.jump       = 1'b1;
            end
            OP_W'(OpBeq): begin
                ctrl.alu_op = AluSub;
                ctrl.branch = 1'b1;
            end
            OP_W'(OpAddi): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_W'(OpLw): begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = M2rMem;
            end
            OP_W'(OpSw): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_W'(OpJ): begin
                ctrl.jump = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage pipeline controller: decodes the IF/ID instruction into the
// ID/EX control register and inserts LU_BUBBLES bubbles on a load-use hazard.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   instr, id_valid     - IF/ID instruction and its valid flag
//   flush               - taken branch/jump; squash the decode instruction
//   stall               - combinational; hold PC and IF/ID this cycle
//   ex_valid .. ex_dest - registered ID/EX control outputs
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned OP_W       = 3,
    parameter int unsigned REG_W      = 3,
    parameter int unsigned LU_BUBBLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               id_valid,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               reg_write,
    output logic               alu_src,
    output logic               branch,
    output logic               jump,
    output logic               mem_write,
    output logic               mem_read,
    output logic [1:0]         reg_dst,
    output logic [1:0]         alu_op,
    output logic [1:0]         mem_to_reg,
    output logic [REG_W-1:0]   ex_dest
);

    localparam int unsigned CntW = $clog2(LU_BUBBLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(LU_BUBBLES - 1);
    localparam int unsigned LowW = INSTR_W - OP_W - 3 * REG_W;

    // Instruction fields, MSB first: op, rs, rt, rd.
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs, rt, rd;

    assign op = instr[INSTR_W-1 -: OP_W];
    assign rs = instr[INSTR_W-OP_W-1 -: REG_W];
    assign rt = instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
    assign rd = instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];

    // Trailing function/immediate bits are not needed for control.
    if (LowW > 0) begin : g_low
        logic unused_low;
        assign unused_low = ^instr[LowW-1:0];
    end

    ctrl_t            dec;
    logic [REG_W-1:0] dec_dest;
    logic             in_bubble;

    ctrl_decode #(
        .OP_W(OP_W)
    ) u_decode (
        .op  (op),
        .ctrl(dec)
    );

    always_comb begin
        case (dec.reg_dst)
            DstRd:   dec_dest = rd;
            DstLink: dec_dest = '1;
            default: dec_dest = rt;
        endcase
    end

    assign in_bubble = !id_valid || (instr == '0);

    ctrl_t            ctrl_q;
    logic             ex_valid_q;
    logic [REG_W-1:0] ex_dest_q;
    state_e           state_q;
    logic [CntW-1:0]  cnt_q;

    // rt is a source only for R-type, BEQ and SW.
    logic rt_read;
    logic hazard;

    assign rt_read = (op == OP_W'(OpRtype)) || (op == OP_W'(OpBeq)) || (op == OP_W'(OpSw));

    // Only evaluated in RUN so a held consumer cannot re-trigger while stalling.
    assign hazard = (state_q == StRun) && ex_valid_q && ctrl_q.mem_read &&
                    (ex_dest_q != '0) &&
                    ((ex_dest_q == rs) || ((ex_dest_q == rt) && rt_read));

    assign stall = reset && !flush && ((state_q == StHold) || hazard);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
            state_q    <= StRun;
            cnt_q      <= '0;
        end else if (flush) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
            state_q    <= StRun;
            cnt_q      <= '0;
        end else if (state_q == StHold) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
            cnt_q      <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                state_q <= StRun;
            end
        end else if (hazard) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
            cnt_q      <= CntLoad;
            state_q    <= (CntLoad != '0) ? StHold : StRun;
        end else if (in_bubble) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
        end else begin
            ctrl_q     <= dec;
            ex_valid_q <= 1'b1;
            ex_dest_q  <= dec_dest;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src    = ctrl_q.alu_src;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_read   = ctrl_q.mem_read;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_op     = ctrl_q.alu_op;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_dest    = ex_dest_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 bubbles per load-use) share one
// stimulus stream; a reference model pushes expected outputs, a monitor pops
// and compares them half a cycle after each rising edge.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       v, rw, as, br, jp, mw, mr;
        logic [1:0] dst, aop, m2r;
        logic [2:0] dest;
    } ex_t;

    typedef struct packed {
        logic stall1;
        ex_t  ex1;
        logic stall3;
        ex_t  ex3;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;

    logic       stall1, stall3;
    logic       v1, rw1, as1, br1, jp1, mw1, mr1;
    logic       v3, rw3, as3, br3, jp3, mw3, mr3;
    logic [1:0] dst1, aop1, m2r1, dst3, aop3, m2r3;
    logic [2:0] dest1, dest3;
    ex_t        obs1, obs3;

    always #5 clock = ~clock;

    pipe_ctrl #(.INSTR_W(16), .OP_W(3), .REG_W(3), .LU_BUBBLES(1)) dut1 (
        .clock(clock), .reset(reset), .instr(instr), .id_valid(id_valid), .flush(flush),
        .stall(stall1), .ex_valid(v1), .reg_write(rw1), .alu_src(as1), .branch(br1),
        .jump(jp1), .mem_write(mw1), .mem_read(mr1), .reg_dst(dst1), .alu_op(aop1),
        .mem_to_reg(m2r1), .ex_dest(dest1)
    );

    pipe_ctrl #(.INSTR_W(16), .OP_W(3), .REG_W(3), .LU_BUBBLES(3)) dut3 (
        .clock(clock), .reset(reset), .instr(instr), .id_valid(id_valid), .flush(flush),
        .stall(stall3), .ex_valid(v3), .reg_write(rw3), .alu_src(as3), .branch(br3),
        .jump(jp3), .mem_write(mw3), .mem_read(mr3), .reg_dst(dst3), .alu_op(aop3),
        .mem_to_reg(m2r3), .ex_dest(dest3)
    );

    assign obs1 = {v1, rw1, as1, br1, jp1, mw1, mr1, dst1, aop1, m2r1, dest1};
    assign obs3 = {v3, rw3, as3, br3, jp3, mw3, mr3, dst3, aop3, m2r3, dest3};

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb[$];

    // Reference state per controller: the ID/EX contents and bubbles still owed.
    ex_t mex[2];
    int  mrem[2];
    int  lu[2] = '{1, 3};

    function automatic ex_t ref_decode(input logic [15:0] ins, input logic vld);
        ex_t e;
        int  op;
        e = '0;
        op = int'(ins[15:13]);
        if (!vld || ins == 16'h0000) return e;
        e.v = 1'b1;
        case (op)
            0: begin e.rw = 1; e.dst = 2'd1; e.aop = 2'd2; end
            1: begin e.rw = 1; e.dst = 2'd2; e.m2r = 2'd2; e.jp = 1; end
            2: begin e.aop = 2'd1; e.br = 1; end
            3: begin e.rw = 1; e.as = 1; end
            5: begin e.rw = 1; e.as = 1; e.mr = 1; e.m2r = 2'd1; end
            6: begin e.as = 1; e.mw = 1; end
            7: begin e.jp = 1; end
            default: ;
        endcase
        if (e.dst == 2'd1) e.dest = ins[6:4];
        else if (e.dst == 2'd2) e.dest = 3'b111;
        else e.dest = ins[9:7];
        return e;
    endfunction

    function automatic logic ref_hazard(input ex_t e, input logic [15:0] ins);
        int op;
        op = int'(ins[15:13]);
        return e.v && e.mr && (e.dest != 3'd0) &&
               ((e.dest == ins[12:10]) ||
                ((e.dest == ins[9:7]) && (op == 0 || op == 2 || op == 6)));
    endfunction

    // One clock of stimulus: drive at the falling edge, queue what the outputs
    // must be now, then advance the model across the next rising edge.
    task automatic step(input logic [15:0] ins, input logic vld, input logic fl,
                        input logic rn);
        exp_t e;
        logic st[2];
        ex_t  cur[2];
        @(negedge clock);
        instr = ins;
        id_valid = vld;
        flush = fl;
        reset = rn;
        for (int k = 0; k < 2; k++) begin
            logic hz;
            hz = (mrem[k] == 0) && ref_hazard(mex[k], ins);
            st[k] = rn && !fl && ((mrem[k] > 0) || hz);
            cur[k] = rn ? mex[k] : '0;
            if (!rn || fl) begin
                mex[k] = '0;
                mrem[k] = 0;
            end else if (mrem[k] > 0) begin
                mex[k] = '0;
                mrem[k] = mrem[k] - 1;
            end else if (hz) begin
                mex[k] = '0;
                mrem[k] = lu[k] - 1;
            end else begin
                mex[k] = ref_decode(ins, vld);
            end
        end
        e.stall1 = st[0];
        e.ex1 = cur[0];
        e.stall3 = st[1];
        e.ex3 = cur[1];
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_lu1", {15'd0, stall1}, {15'd0, e.stall1});
                chk("idex_lu1", obs1, e.ex1);
                chk("stall_lu3", {15'd0, stall3}, {15'd0, e.stall3});
                chk("idex_lu3", obs3, e.ex3);
                cyc++;
            end
        end
    end

    localparam logic [15:0] LwR2  = 16'hA500; // LW r2,(r1)
    localparam logic [15:0] AddR3 = 16'h08B0; // ADD r3,r2,r1
    localparam logic [15:0] LwR0  = 16'hA400; // LW r0,(r1)
    localparam logic [15:0] UseR0 = 16'h0030; // ADD r3,r0,r0
    localparam logic [15:0] LwR3  = 16'hA980; // LW r3,(r2)
    localparam logic [15:0] UseR3 = 16'h0C40; // ADD r4,r3,r0
    localparam logic [15:0] Jal   = 16'h2000;
    localparam logic [15:0] SwR2  = 16'hC500; // SW r2 -> base r1, data r2 via rt

    initial begin
        logic [15:0] ri;
        logic [15:0] prev;
        mex[0] = '0;
        mex[1] = '0;
        mrem[0] = 0;
        mrem[1] = 0;

        // Reset, then idle zeros
        repeat (3) step(16'h0000, 1'b1, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b1, 1'b0, 1'b1);

        // Load-use: consumer held while stalled
        step(LwR2, 1'b1, 1'b0, 1'b1);
        repeat (5) step(AddR3, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b1, 1'b0, 1'b1);

        // Load to r0 never stalls
        step(LwR0, 1'b1, 1'b0, 1'b1);
        repeat (2) step(UseR0, 1'b1, 1'b0, 1'b1);

        // Flush in the second HOLD cycle of the 3-bubble controller
        step(LwR2, 1'b1, 1'b0, 1'b1);
        step(AddR3, 1'b1, 1'b0, 1'b1);
        step(AddR3, 1'b1, 1'b0, 1'b1);
        step(AddR3, 1'b1, 1'b1, 1'b1);
        repeat (2) step(AddR3, 1'b1, 1'b0, 1'b1);

        // JAL
        step(Jal, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b1, 1'b0, 1'b1);

        // Reset during HOLD, consumer decodes straight after release
        step(LwR2, 1'b1, 1'b0, 1'b1);
        step(AddR3, 1'b1, 1'b0, 1'b1);
        step(AddR3, 1'b0, 1'b0, 1'b0);
        repeat (2) step(AddR3, 1'b1, 1'b0, 1'b1);

        // Dependent load chain, rt-consumer via SW, invalid slot
        step(LwR2, 1'b1, 1'b0, 1'b1);
        repeat (4) step(LwR3, 1'b1, 1'b0, 1'b1);
        repeat (4) step(UseR3, 1'b1, 1'b0, 1'b1);
        step(LwR2, 1'b1, 1'b0, 1'b1);
        repeat (4) step(SwR2, 1'b1, 1'b0, 1'b1);
        step(LwR2, 1'b0, 1'b0, 1'b1);
        step(AddR3, 1'b1, 1'b0, 1'b1);

        // Random traffic with small register numbers to provoke hazards
        prev = 16'h0000;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                ri = prev;
            end else if ($urandom_range(0, 19) == 0) begin
                ri = 16'h0000;
            end else begin
                ri[15:13] = 3'($urandom_range(0, 7));
                ri[12:10] = 3'($urandom_range(0, 3));
                ri[9:7]   = 3'($urandom_range(0, 3));
                ri[6:4]   = 3'($urandom_range(0, 7));
                ri[3:0]   = 4'($urandom_range(0, 15));
            end
            prev = ri;
            step(ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 59) != 0));
        end

        @(negedge clock);
        #5;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0 entries left", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter INSTR_W, default 16: instruction width.
REQ-002 SHALL provide parameter OP_W, default 3: opcode width, taken from instr[INSTR_W-1 -: OP_W].
REQ-003 SHALL provide parameter REG_W, default 3: register address width; rs, rt and rd follow the opcode in that order, MSB first.
REQ-004 SHALL provide parameter LU_BUBBLES, default 1, legal range 1..3: bubbles inserted per load-use hazard.
REQ-005 clock  in  1  rising-edge clock, single domain.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 instr  in  INSTR_W  IF/ID instruction.
REQ-008 id_valid  in  1  IF/ID holds a real instruction.
REQ-009 flush  in  1  taken branch/jump; squash the instruction in decode.
REQ-010 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-011 ex_valid, reg_write, alu_src, branch, jump, mem_write, mem_read  out  1 each  registered ID/EX control bits.
REQ-012 reg_dst, alu_op, mem_to_reg  out  2 each  registered ID/EX control fields.
REQ-013 ex_dest  out  REG_W  registered write register: rt, rd, or all-ones for link, per reg_dst 0/1/2.

Function
REQ-014 Decode SHALL be: op0 R-type (rw=1, dst=1, aluop=2); op1 JAL (rw=1, dst=2, m2r=2, jump=1); op2 BEQ (aluop=1, branch=1); op3 ADDI (rw=1, alusrc=1); op5 LW (rw=1, alusrc=1, mread=1, m2r=1); op6 SW (alusrc=1, mwrite=1); op7 J (jump=1); every other opcode and every unlisted field SHALL be 0.
REQ-015 instr==0 or id_valid=0 SHALL load a bubble: all ID/EX outputs 0, including ex_valid.
REQ-016 Every non-bubble decode SHALL reach the ID/EX outputs one clock after it is presented (latency 1), with ex_valid=1.
REQ-017 Hazard SHALL be: ex_valid & mem_read & ex_dest!=0 & (ex_dest==rs, or ex_dest==rt for op0, op2 or op6).
REQ-018 FSM SHALL have states RUN and HOLD, plus a bubble counter of ceil(log2(LU_BUBBLES+1)) bits.
REQ-019 RUN with hazard and no flush: stall=1, load a bubble, counter=LU_BUBBLES-1; go to HOLD if the counter is nonzero, else stay in RUN.
REQ-020 HOLD: stall=1, load a bubble, decrement the counter; return to RUN when the counter reaches 0.
REQ-021 flush SHALL have priority in any state: load a bubble, stall=0, state=RUN, counter=0.
REQ-022 Hazard detection SHALL be suppressed in HOLD, so no re-trigger occurs while stalling.
REQ-023 After the stall releases, the held instruction SHALL decode normally on the next edge.
REQ-024 Back-to-back loads with a dependent chain SHALL each stall independently; there SHALL be no counter wrap.

Reset
REQ-025 While reset=0, all registered outputs, the state and the counter SHALL be 0 (state RUN), asynchronously, and stall SHALL be 0.
REQ-026 Reset asserted mid-HOLD SHALL abort the stall; the first edge after release SHALL decode instr with no residual bubble.

Structure
REQ-027 Package pipe_ctrl_pkg SHALL hold: opcode constants, ALUOp/RegDst/MemtoReg encodings, the control-bundle struct, and the FSM state enum.
REQ-028 The pure opcode-to-bundle decode SHALL be a combinational sub-module ctrl_decode; the hazard logic, FSM and ID/EX register SHALL live in pipe_ctrl.

Verification
REQ-029 Reset low, then release, instr=0x0000, id_valid=1 -> all outputs 0 and stall=0 on every edge.
REQ-030 LW r2,(r1) = 0xA500 then ADD r3,r2,r1 = 0x08B0 -> stall=1 for exactly 1 cycle, one bubble, then ADD shows reg_write=1, reg_dst=1, alu_op=2, ex_dest=3.
REQ-031 Same sequence with LU_BUBBLES=3 -> stall=1 for 3 consecutive cycles, 3 bubbles, then ADD issues.
REQ-032 LW r0 (ex_dest=0) followed by a consumer of r0 -> stall stays 0.
REQ-033 flush=1 in the second HOLD cycle with LU_BUBBLES=3 -> that edge loads a bubble, stall=0, state RUN.
REQ-034 JAL opcode 1 -> next edge reg_write=1, reg_dst=2, mem_to_reg=2, jump=1, ex_dest=7.
